zap_store_aligner: RTL and testbench
====================================

ZAP_STORE_ALIGNER -- requirements
Module: zap_store_aligner

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, number of buffered store entries (power of 2, >=2).
REQ-002 SHALL have port i_clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port i_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_clear  input  1  pipeline flush from writeback.
REQ-005 SHALL have port i_st_valid  input  1  store request valid.
REQ-006 SHALL have port o_st_ready  output  1  entry can be accepted.
REQ-007 SHALL have port i_st_addr  input  32  byte address of store.
REQ-008 SHALL have port i_st_data  input  32  unaligned source register value.
REQ-009 SHALL have ports i_byte, i_half  input  1 each  access size; neither set = word; both set = byte.
REQ-010 SHALL have port o_wr_stb  output  1  write request to cache.
REQ-011 SHALL have port o_wr_addr  output  32  word-aligned address (bits[1:0]=0).
REQ-012 SHALL have port o_wr_data  output  32  lane-replicated write data.
REQ-013 SHALL have port o_wr_sel  output  4  byte enables.
REQ-014 SHALL have port i_wr_ack  input  1  cache accepted current request.
REQ-015 SHALL have port i_wr_err  input  1  fault; qualified by i_wr_ack.
REQ-016 SHALL have port o_data_abort  output  1  one-cycle abort pulse.
REQ-017 SHALL have port o_busy  output  1  any entry pending or in flight.

Function
REQ-018 SHALL accept an entry in any cycle where i_st_valid && o_st_ready && !i_clear.
REQ-019 SHALL drive o_st_ready = (occupancy < FIFO_DEPTH) from registered occupancy; a pop in the same cycle SHALL NOT make a full buffer ready.
REQ-020 SHALL format at accept: byte -> data {4{d[7:0]}}, sel 4'b0001<<addr[1:0]; half -> data {2{d[15:0]}}, sel addr[1]?4'b1100:4'b0011, addr[0] ignored; word -> data unchanged (no rotation), sel 4'b1111, addr[1:0] ignored.
REQ-021 SHALL use state machine IDLE (stb=0) and ISSUE (stb=1); IDLE->ISSUE when occupancy becomes nonzero; ISSUE->IDLE on ack when no further entry remains.
REQ-022 SHALL assert o_wr_stb no earlier than the cycle after accept (minimum latency 1 cycle, registered outputs).
REQ-023 SHALL hold o_wr_addr/data/sel stable while o_wr_stb=1 and i_wr_ack=0.
REQ-024 SHALL, on ack with a further entry buffered, present it the next cycle with o_wr_stb held high (back-to-back, one store per cycle throughput).
REQ-025 SHALL issue entries strictly in acceptance order; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-026 SHALL allow simultaneous accept and ack-pop; occupancy unchanged.
REQ-027 SHALL, on i_clear, discard all entries not yet presented; an in-flight request (stb=1) SHALL remain until acked and then complete.
REQ-028 SHALL, on i_wr_ack && i_wr_err, pulse o_data_abort for one cycle, discard all remaining entries, and return to IDLE.
REQ-029 SHALL ignore i_wr_ack/i_wr_err when o_wr_stb=0.
REQ-030 SHALL drive o_busy = (occupancy != 0) || o_wr_stb.

Reset
REQ-031 SHALL, while i_reset_n=0, force o_wr_stb=0, o_data_abort=0, o_busy=0, o_st_ready=1, occupancy/pointers=0, state IDLE, o_wr_addr/data/sel=0.
REQ-032 SHALL abandon any in-flight request on reset mid-operation without waiting for ack.

Structure
REQ-033 SHALL take size encodings and sel constants from the shared zap package; state enum local.
REQ-034 SHALL instantiate one sub-module zap_sync_fifo (storage of {addr[31:2], data, sel}, FIFO_DEPTH entries).

Verification
REQ-035 SHALL cover byte store addr 0x1003 data 0x000000A5 -> addr 0x1000, data 0xA5A5A5A5, sel 4'b1000.
REQ-036 SHALL cover half store addr 0x2002 data 0x1234BEEF -> data 0xBEEFBEEF, sel 4'b1100; word addr 0x2001 -> addr 0x2000, sel 4'b1111, data unrotated.
REQ-037 SHALL cover 3 back-to-back stores with ack held high, DEPTH=2 -> ready low after 2 accepts, stb high 3 consecutive cycles, order preserved.
REQ-038 SHALL cover i_clear with one entry in flight and one buffered, ack delayed 3 cycles -> in-flight held stable then completes; buffered entry never issued.
REQ-039 SHALL cover ack+err on first of two entries -> o_data_abort high exactly one cycle, second entry never issued, o_busy=0 next cycle.
REQ-040 SHALL cover i_reset_n low during ISSUE -> o_wr_stb=0 immediately (asynchronous), o_st_ready=1.

Source files
------------

// File: rtl/zap_store_aligner_pkg.sv
// Shared definitions for the store aligner: access-size encoding, byte-enable
// constants, the buffered entry layout and the lane-formatting helper.
package zap_store_aligner_pkg;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_BYTE = 2'd2
    } zap_size_e;

    localparam logic [3:0] SEL_WORD    = 4'b1111;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_BYTE0   = 4'b0001;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } zap_st_entry_t;

    localparam int unsigned ENTRY_W = $bits(zap_st_entry_t);

    // Byte wins when both size flags are set.
    function automatic zap_size_e decode_size(input logic is_byte, input logic is_half);
        if (is_byte)
            return SIZE_BYTE;
        else if (is_half)
            return SIZE_HALF;
        return SIZE_WORD;
    endfunction

    function automatic zap_st_entry_t format_store(input logic [31:0] addr,
                                                   input logic [31:0] data,
                                                   input zap_size_e   size);
        zap_st_entry_t e;
        e.addr = addr[31:2];
        case (size)
            SIZE_BYTE: begin
                e.data = {4{data[7:0]}};
                e.sel  = SEL_BYTE0 << addr[1:0];
            end
            SIZE_HALF: begin
                e.data = {2{data[15:0]}};
                e.sel  = addr[1] ? SEL_HALF_HI : SEL_HALF_LO;
            end
            default: begin
                e.data = data;
                e.sel  = SEL_WORD;
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/zap_store_aligner_fifo.sv
// Store entry buffer with head/next read ports and a flush that can keep
// the head entry (the request currently presented to the cache).
module zap_sync_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 66
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic                         keep_head,
    input  logic [WIDTH-1:0]             wr_entry,
    output logic [WIDTH-1:0]             head,
    output logic [WIDTH-1:0]             next,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PW = $clog2(DEPTH);
    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t             rd_ptr;
    ptr_t             wr_ptr;
    ptr_t             rd_after;
    logic             keep;

    assign rd_after = rd_ptr + ptr_t'(pop);
    assign keep     = keep_head && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Everything behind the (optionally kept) head is dropped.
            rd_ptr <= rd_after;
            wr_ptr <= rd_after + ptr_t'(keep);
            count  <= cnt_t'(keep);
        end else begin
            if (push)
                wr_ptr <= wr_ptr + ptr_t'(1);
            rd_ptr <= rd_after;
            count  <= count + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= wr_entry;
    end

    assign head = mem[rd_ptr];
    assign next = mem[rd_ptr + ptr_t'(1)];

endmodule

// File: rtl/zap_store_aligner.sv
// Store aligner: formats stores into word-aligned, lane-replicated cache
// writes, buffers them in order and issues them with a stb/ack handshake.
module zap_store_aligner
    import zap_store_aligner_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clear,
    input  logic        i_st_valid,
    output logic        o_st_ready,
    input  logic [31:0] i_st_addr,
    input  logic [31:0] i_st_data,
    input  logic        i_byte,
    input  logic        i_half,
    output logic        o_wr_stb,
    output logic [31:0] o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic [3:0]  o_wr_sel,
    input  logic        i_wr_ack,
    input  logic        i_wr_err,
    output logic        o_data_abort,
    output logic        o_busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_e;

    state_e          state;
    state_e          state_next;
    logic [CW-1:0]   count;
    logic            accept;
    logic            ack;
    logic            err;
    logic            load;
    logic            flush;
    zap_st_entry_t   fmt_entry;
    zap_st_entry_t   head_entry;
    zap_st_entry_t   next_entry;
    zap_st_entry_t   load_entry;
    zap_st_entry_t   out_entry;

    assign o_st_ready = (count < CW'(FIFO_DEPTH));
    assign accept     = i_st_valid && o_st_ready && !i_clear;
    assign ack        = (state == ISSUE) && i_wr_ack;
    assign err        = ack && i_wr_err;
    assign flush      = i_clear || err;
    assign fmt_entry  = format_store(i_st_addr, i_st_data, decode_size(i_byte, i_half));

    // The presented entry stays in the buffer until acked, so occupancy
    // includes the in-flight request.
    zap_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_reset_n),
        .push      (accept),
        .pop       (ack),
        .flush     (flush),
        .keep_head (state == ISSUE),
        .wr_entry  (fmt_entry),
        .head      (head_entry),
        .next      (next_entry),
        .count     (count)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_entry = head_entry;
        case (state)
            IDLE: begin
                if (!i_clear && count != '0) begin
                    state_next = ISSUE;
                    load       = 1'b1;
                end
            end
            ISSUE: begin
                if (err) begin
                    state_next = IDLE;
                end else if (ack) begin
                    if (!i_clear && count > CW'(1)) begin
                        load       = 1'b1;
                        load_entry = next_entry;
                    end else if (count == CW'(1) && accept) begin
                        // Buffer empties on this ack: forward the store
                        // being accepted now to keep the strobe high.
                        load       = 1'b1;
                        load_entry = fmt_entry;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            out_entry    <= '0;
            o_data_abort <= 1'b0;
        end else begin
            o_data_abort <= err;
            if (load)
                out_entry <= load_entry;
        end
    end

    assign o_wr_stb  = (state == ISSUE);
    assign o_wr_addr = {out_entry.addr, 2'b00};
    assign o_wr_data = out_entry.data;
    assign o_wr_sel  = out_entry.sel;
    assign o_busy    = (count != '0) || o_wr_stb;

endmodule

// File: tb/tb_zap_store_aligner.sv
// Scoreboard bench for zap_store_aligner: expected writes are queued at
// accept time and compared by a monitor on every acked strobe.
module tb_zap_store_aligner;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        is_byte = 1'b0;
    logic        is_half = 1'b0;
    logic        wr_stb;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_sel;
    logic        wr_ack = 1'b0;
    logic        wr_err = 1'b0;
    logic        data_abort;
    logic        busy;

    int unsigned checks = 0;
    int unsigned failures = 0;
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    zap_store_aligner #(
        .FIFO_DEPTH (2)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_clear      (clear),
        .i_st_valid   (st_valid),
        .o_st_ready   (st_ready),
        .i_st_addr    (st_addr),
        .i_st_data    (st_data),
        .i_byte       (is_byte),
        .i_half       (is_half),
        .o_wr_stb     (wr_stb),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_wr_sel     (wr_sel),
        .i_wr_ack     (wr_ack),
        .i_wr_err     (wr_err),
        .o_data_abort (data_abort),
        .o_busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every acked strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && wr_stb && wr_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%h/%h/%b required=none", wr_addr, wr_data, wr_sel);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_addr", wr_addr, e.a);
                check("wr_data", wr_data, e.d);
                check("wr_sel", {28'd0, wr_sel}, {28'd0, e.s});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic b, input logic h);
        st_addr = a;
        st_data = d;
        is_byte = b;
        is_half = h;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic b, input logic h,
                        input exp_t e, input logic expect_issue);
        int unsigned n = 0;
        set_store(a, d, b, h);
        st_valid = 1'b1;
        while (!st_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_ready", {31'd0, st_ready}, 32'd1);
        if (expect_issue)
            exp_q.push_back(e);
        @(posedge clk); #1;
        st_valid = 1'b0;
    endtask

    task automatic wait_stb();
        int unsigned n = 0;
        while (!wr_stb && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_stb", {31'd0, wr_stb}, 32'd1);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (busy && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    exp_t vec_e[6];
    logic [31:0] vec_a[6];
    logic [31:0] vec_d[6];
    logic [1:0]  vec_bh[6];

    initial begin
        int unsigned n_acc;
        int unsigned run;
        int unsigned max_run;
        int unsigned wait_n;

        // Reset state
        #12;
        check("rst_stb", {31'd0, wr_stb}, 32'd0);
        check("rst_ready", {31'd0, st_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_abort", {31'd0, data_abort}, 32'd0);
        check("rst_addr", wr_addr, 32'd0);
        check("rst_data", wr_data, 32'd0);
        check("rst_sel", {28'd0, wr_sel}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single formatted stores with ack held high
        vec_a[0] = 32'h0000_1003; vec_d[0] = 32'h0000_00A5; vec_bh[0] = 2'b10; vec_e[0] = '{32'h0000_1000, 32'hA5A5_A5A5, 4'b1000};
        vec_a[1] = 32'h0000_2002; vec_d[1] = 32'h1234_BEEF; vec_bh[1] = 2'b01; vec_e[1] = '{32'h0000_2000, 32'hBEEF_BEEF, 4'b1100};
        vec_a[2] = 32'h0000_2001; vec_d[2] = 32'h1122_3344; vec_bh[2] = 2'b00; vec_e[2] = '{32'h0000_2000, 32'h1122_3344, 4'b1111};
        vec_a[3] = 32'h0000_1000; vec_d[3] = 32'h1234_5678; vec_bh[3] = 2'b10; vec_e[3] = '{32'h0000_1000, 32'h7878_7878, 4'b0001};
        vec_a[4] = 32'h0000_2001; vec_d[4] = 32'hCAFE_1234; vec_bh[4] = 2'b01; vec_e[4] = '{32'h0000_2000, 32'h1234_1234, 4'b0011};
        vec_a[5] = 32'h0000_3002; vec_d[5] = 32'hFFFF_FF5A; vec_bh[5] = 2'b11; vec_e[5] = '{32'h0000_3000, 32'h5A5A_5A5A, 4'b0100};
        wr_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(vec_a[i], vec_d[i], vec_bh[i][1], vec_bh[i][0], vec_e[i], 1'b1);
            wait_idle();
        end

        // Three stores offered back-to-back, ack held high
        vec_a[0] = 32'h0000_4000; vec_d[0] = 32'h0A0A_0A0A; vec_bh[0] = 2'b00; vec_e[0] = '{32'h0000_4000, 32'h0A0A_0A0A, 4'b1111};
        vec_a[1] = 32'h0000_4005; vec_d[1] = 32'h0000_00C3; vec_bh[1] = 2'b10; vec_e[1] = '{32'h0000_4004, 32'hC3C3_C3C3, 4'b0010};
        vec_a[2] = 32'h0000_400A; vec_d[2] = 32'hDEAD_7777; vec_bh[2] = 2'b01; vec_e[2] = '{32'h0000_4008, 32'h7777_7777, 4'b1100};
        n_acc = 0; run = 0; max_run = 0;
        set_store(vec_a[0], vec_d[0], vec_bh[0][1], vec_bh[0][0]);
        st_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            logic took;
            took = st_valid && st_ready;
            if (took)
                exp_q.push_back(vec_e[n_acc]);
            if (wr_stb) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            @(posedge clk); #1;
            if (took) begin
                n_acc++;
                if (n_acc == 2)
                    check("b2b_ready_full", {31'd0, st_ready}, 32'd0);
                if (n_acc < 3)
                    set_store(vec_a[n_acc], vec_d[n_acc], vec_bh[n_acc][1], vec_bh[n_acc][0]);
                else
                    st_valid = 1'b0;
            end
        end
        check("b2b_accepts", n_acc, 32'd3);
        check("b2b_stb_run", max_run, 32'd3);
        wait_idle();

        // Clear with one request in flight and one buffered
        wr_ack = 1'b0;
        send(32'h0000_6000, 32'h1111_2222, 1'b0, 1'b0, '{32'h0000_6000, 32'h1111_2222, 4'b1111}, 1'b1);
        send(32'h0000_6004, 32'h3333_4444, 1'b0, 1'b0, '{32'h0, 32'h0, 4'h0}, 1'b0);
        wait_stb();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("clr_hold_stb", {31'd0, wr_stb}, 32'd1);
            check("clr_hold_addr", wr_addr, 32'h0000_6000);
            check("clr_hold_data", wr_data, 32'h1111_2222);
            @(posedge clk); #1;
        end
        wr_ack = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) begin
            check("clr_no_issue", {31'd0, wr_stb}, 32'd0);
            @(posedge clk); #1;
        end
        check("clr_busy", {31'd0, busy}, 32'd0);

        // Error on the first of two entries
        wr_ack = 1'b0;
        send(32'h0000_5000, 32'h5555_5555, 1'b0, 1'b0, '{32'h0000_5000, 32'h5555_5555, 4'b1111}, 1'b1);
        send(32'h0000_5004, 32'h6666_6666, 1'b0, 1'b0, '{32'h0, 32'h0, 4'h0}, 1'b0);
        wait_stb();
        check("err_abort_before", {31'd0, data_abort}, 32'd0);
        wr_ack = 1'b1;
        wr_err = 1'b1;
        @(posedge clk); #1;
        wr_ack = 1'b0;
        wr_err = 1'b0;
        check("err_abort_pulse", {31'd0, data_abort}, 32'd1);
        check("err_busy", {31'd0, busy}, 32'd0);
        check("err_stb", {31'd0, wr_stb}, 32'd0);
        @(posedge clk); #1;
        check("err_abort_end", {31'd0, data_abort}, 32'd0);
        wr_ack = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("err_no_issue", {31'd0, wr_stb}, 32'd0);

        // Asynchronous reset while a request is presented
        wr_ack = 1'b0;
        send(32'h0000_7000, 32'h7777_0000, 1'b0, 1'b0, '{32'h0, 32'h0, 4'h0}, 1'b0);
        wait_stb();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_stb", {31'd0, wr_stb}, 32'd0);
        check("arst_ready", {31'd0, st_ready}, 32'd1);
        check("arst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wr_ack = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("arst_idle", {31'd0, wr_stb}, 32'd0);
        wr_ack = 1'b0;

        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 20) begin
            @(posedge clk); #1;
            wait_n++;
        end
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
